// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full adder over WIDTH cycles
// Optional subtract port enabled by defining SERIAL_ADD_SUB_EN.

module serial_add_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cy_out_q, cy_out_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_full;
    logic [WIDTH-1:0] b_load;
    logic             seed_load;

    serial_add_fa u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // The newest sum bit enters at the MSB; after the last shift this is the whole result.
    assign sum_full = {fa_s, sum_sh_q};

`ifdef SERIAL_ADD_SUB_EN
    assign b_load    = sub ? ~b : b;
    assign seed_load = sub ? 1'b1 : cy_in;
`else
    assign b_load    = b;
    assign seed_load = cy_in;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cy_out    = cy_out_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cy_out_d = cy_out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = seed_load;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_full[WIDTH-1:1];
                carry_d  = fa_co;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    sum_d    = sum_full;
                    cy_out_d = fa_co;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cy_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cy_out_q <= cy_out_d;
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed-vector bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cy_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_s;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cy_out;

    int n_vec = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cy_in     (cy_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cy_out    (cy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request with out_ready high; optionally churns operands while running.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input bit churn,
                          input logic [7:0] es, input logic ec);
        int lat;
        a        = ta;
        b        = tb_v;
        cy_in    = tc;
        in_valid = 1'b1;
        check({tag, "_ready_before"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (churn) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                cy_in = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cy"}, cy_out, ec);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cy_in     = 1'b0;
        out_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub_s     = 1'b0;
`endif
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cy", cy_out, 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("basic",  8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        run_op("wrap1",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("wrap2",  8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        run_op("seed",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        run_op("msb",    8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("churn",  8'hC3, 8'h5D, 1'b1, 1'b1, 8'h21, 1'b1);

        // Backpressure: result held, second request blocked until the handshake.
        out_ready = 1'b0;
        a = 8'h11; b = 8'h22; cy_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h01; b = 8'h01; cy_in = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", out_valid, 1);
            check("bp_sum_hold", sum, 8'h33);
            check("bp_cy_hold", cy_out, 0);
            check("bp_no_accept", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_accepted", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp2_latency", lat, 8);
        check("bp2_sum", sum, 8'h02);
        check("bp2_cy", cy_out, 0);
        @(posedge clk); #1;

        // Asynchronous reset after the 3rd RUN edge.
        a = 8'hAA; b = 8'h55; cy_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cy", cy_out, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", out_valid, 0);
        run_op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub_s = 1'b1;
        run_op("sub1",    8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b1);
        run_op("sub2",    8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b0);
        run_op("sub_cyin", 8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1);
        sub_s = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It accepts a WIDTH-bit add request over a valid/ready handshake and sequences a single shared one-bit full adder (sum = a^b^c, carry = majority) over WIDTH clock cycles, LSB first. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the area-minimal alternative to the combinational ripple-carry adder and is used wherever add throughput of one result per WIDTH+2 cycles is sufficient.

## Interface
- WIDTH, 8: operand and sum width in bits. Legal values are 2 to 64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request. High only in IDLE.
- a  input  WIDTH  operand A. Sampled only on the accept edge.
- b  input  WIDTH  operand B. Sampled only on the accept edge.
- cy_in  input  1  carry seed. Sampled only on the accept edge.
- sub  input  1  subtract select. Present only with SERIAL_ADD_SUB_EN.
- out_valid  output  1  result present. Held until accepted.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result. Registered and stable while out_valid is high.
- cy_out  output  1  final carry. Registered and stable while out_valid is high.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: processing bits.
  - DONE: out_valid=1.
- IDLE→RUN on the edge where in_valid & in_ready (the accept edge). On that edge:
  - a and b are loaded into shift registers a_sh and b_sh.
  - cy_in is loaded into the carry flop.
  - The bit counter is cleared to 0.
- RUN, each edge:
  - The full adder takes a_sh[0], b_sh[0] and the carry flop.
  - The sum bit shifts into sum_sh at the MSB. a_sh and b_sh shift right.
  - The carry flop takes the adder carry. The counter increments.
- RUN→DONE on the edge where the counter equals WIDTH-1, i.e. the WIDTH-th RUN edge. On that edge:
  - sum is loaded with the fully shifted sum_sh value.
  - cy_out is loaded with the final carry.
- DONE→IDLE on the edge where out_valid & out_ready. sum and cy_out keep their values until the next DONE load.
- Behaviour in RUN and DONE:
  - in_valid is ignored. Requests are not queued.
  - Changes on a, b and cy_in have no effect.
- Arithmetic: {cy_out, sum} = a + b + cy_in, exact over WIDTH+1 bits. Wrap-around is represented only by cy_out.
- Exactly one full-adder instance exists. No WIDTH-wide adder is inferred.
- Reset (asserted at any time, including mid-RUN or in DONE):
  - Immediately forces IDLE, in_ready=1, out_valid=0, sum=0, cy_out=0.
  - Clears the shift registers, counter and carry flop.
  - Any in-flight operation is discarded without a result.

## Timing
- Accept edge at E0. out_valid rises after edge E0+WIDTH, i.e. latency is WIDTH cycles.
- Minimum request-to-request spacing is WIDTH+2 cycles:
  - accept edge E0;
  - WIDTH RUN edges;
  - result accept at E0+WIDTH+1 with out_ready held high;
  - in_ready high again from E0+WIDTH+1.
- in_ready and out_valid are pure state decodes. There is no combinational path from any input to any output.
- out_ready held low keeps DONE indefinitely. sum, cy_out and out_valid stay constant.

## Configuration
- SERIAL_ADD_SUB_EN:
  - Defined:
    - Adds the sub port, which is sampled on the accept edge.
    - sub=1 loads ~b into b_sh and forces the carry seed to 1. cy_in is ignored. The block computes a-b.
    - cy_out=1 means no borrow.
  - Undefined: the sub port is absent and the block is add-only.

## Test plan
- WIDTH=8: a=0x5A, b=0x3C, cy_in=0, out_ready=1.
  - Required: sum=0x96, cy_out=0.
  - out_valid rises exactly 8 cycles after the accept edge and lasts 1 cycle.
  - in_ready returns 1 cycle later.
- Wrap cases:
  - 0xFF+0x01, cy_in=0 → sum=0x00, cy_out=1.
  - 0xFF+0xFF, cy_in=1 → sum=0xFF, cy_out=1.
  - 0x00+0x00, cy_in=1 → sum=0x01, cy_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - sum, cy_out and out_valid stay stable.
  - in_ready stays 0. A second request with in_valid=1 is not accepted.
  - It is accepted on the first edge after the result handshake.
- Operand churn: randomize a, b and cy_in every cycle during RUN.
  - The result matches only the values sampled on the accept edge.
- Reset mid-RUN: assert rst_n=0 after the 3rd RUN edge.
  - Immediately: out_valid=0, sum=0, cy_out=0, in_ready=1.
  - Next request 0x12+0x34 → sum=0x46, cy_out=0.
- With SERIAL_ADD_SUB_EN:
  - 0x10-0x01 → sum=0x0F, cy_out=1.
  - 0x00-0x01 → sum=0xFF, cy_out=0.
  - cy_in is ignored when sub=1.
